vector_alu_exec: RTL
====================

Name: vector_alu_exec

Overview:
Multi-cycle vector execution unit that consumes the 3-bit ALUControl and SrcA outputs of the control-unit ALU decoder and executes the operation lane-serially over a packed vector.
Sits between the register-file read stage and writeback.
Uses a start/busy/done handshake so the control unit can stall on long operations, in particular the iterative DIV.

Parameters:
LANES, 4, number of vector elements
EW, 8, element width in bits

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  launch operation; sampled only in IDLE
alu_control  in  3  operation code: 000 ADD, 001 SUB, 010 MOV, 011 MUL, 100 DIV, 101 CMP, 110 NOP (non-DP), 111 DUP
src_a  in  1  1 = operand A forced to zero (MOV path); 0 = vec_a
vec_a  in  LANES*EW  operand A; lane i = bits [i*EW +: EW]
vec_b  in  LANES*EW  operand B
busy  out  1  high from the cycle after an accepted start until done
done  out  1  single-cycle completion pulse
result  out  LANES*EW  result vector; held until the next accepted start
cmp_eq  out  LANES  per-lane A==B mask (CMP only)
flag_z  out  1  CMP: all lanes equal
flag_n  out  1  CMP: lane 0 (A-B) bit EW-1

Behaviour:
- Reset: FSM to IDLE. busy, done, result, cmp_eq, flag_z and flag_n all 0. Any in-flight operation is aborted and no done pulse is produced.
- Accept: start=1 in IDLE (cycle T). At T, latch alu_control, src_a, vec_a (or zero when src_a=1) and vec_b. start is ignored while busy.
- FSM states: IDLE, RUN, DIV, FIN.
  - IDLE->RUN when start and the code is not 100 or 110.
  - IDLE->DIV when start and the code is 100.
  - IDLE->FIN when start and the code is 110.
  - RUN steps a lane index 0..LANES-1, one lane per cycle; after the last lane it goes to FIN.
  - DIV spends EW iteration cycles per lane plus 1 writeback cycle; after the last lane it goes to FIN.
  - FIN asserts done for one cycle, clears busy, then returns to IDLE.
- Latency (start at T, done high at):
  - RUN ops: T+LANES+1
  - DIV: T+LANES*(EW+1)+1
  - NOP: T+1
- Arithmetic, unsigned and modulo 2^EW:
  - ADD: A+B
  - SUB: A-B
  - MUL: low EW bits of A*B
  - MOV: 0+B, i.e. B
  - DUP: every lane gets lane 0 of B
  - DIV: restoring quotient A/B. B=0 gives a quotient of all ones.
- CMP: result is not modified. cmp_eq[i] = (A_i==B_i). flag_z = &cmp_eq. flag_n = MSB of (A_0-B_0). Flags are updated only by CMP and hold otherwise.
- NOP: result and flags are held; only the done pulse is produced.
- Result lanes are written as each lane completes. The final vector is valid when done=1 and stays stable afterwards.
- Back-to-back: start may be asserted in the cycle done is high; it is ignored because FIN is not IDLE. The earliest new accept is the cycle after done.
- Unknown codes cannot occur; the 3-bit space is fully decoded.

Optional Feature:
VALU_SAT_EN
- Defined: ADD clamps to 2^EW-1 on carry out. SUB clamps to 0 on borrow. MUL clamps to 2^EW-1 when any high product bit is set. DIV, MOV, DUP and CMP are unchanged.
- Undefined: plain modulo-2^EW wrap as specified above; no clamp logic is instantiated.

Decomposition:
- Package valu_pkg:
  - alu_op_e enum with the 3-bit codes above (ADD=3'b000 ... DUP=3'b111)
  - fsm state enum
  - localparam DIV_DIVZERO_Q = all ones
- Sub-module valu_div_iter: single-lane restoring divider.
  - One quotient bit per cycle over EW cycles.
  - Ports: start, dividend, divisor, quotient, valid.
  - Instantiated once and reused per lane.

Test Plan:
- ADD: vec_a={8'd250,8'd3,8'd2,8'd1}, vec_b={8'd10,8'd4,8'd4,8'd4}, start at T -> done at T+5, result={8'd4,8'd7,8'd6,8'd5}. With VALU_SAT_EN, lane 3 = 8'd255.
- MOV/DUP: src_a=1, code 010, vec_a=all 8'hFF, vec_b={1,2,3,4} -> result={1,2,3,4}. Then code 111 with the same vec_b -> all lanes 8'd4 (lane 0 = 4), done at T+5.
- DIV: A={100,7,9,200}, B={0,2,3,10} -> done at T+37, result={8'hFF,8'd3,8'd3,8'd20}. busy is high for exactly 36 cycles.
- CMP: A={5,6,7,8}, B={5,0,7,9} -> cmp_eq=4'b1010, flag_z=0, flag_n=1 (8-9 negative), result unchanged from the prior op. A==B -> flag_z=1.
- Handshake: start held high for 10 cycles during a DIV -> exactly one operation and one done pulse. Code 110 -> done at T+1 with result unchanged.
- Reset mid-DIV at T+12 -> next cycle busy=0, done=0, result=0. A new start is accepted in the following cycle.

Source files
------------

// File: rtl/valu_pkg.sv
// Shared types for the lane-serial vector ALU: opcodes, FSM states, divide-by-zero quotient.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package valu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MOV = 3'b010,
        OP_MUL = 3'b011,
        OP_DIV = 3'b100,
        OP_CMP = 3'b101,
        OP_NOP = 3'b110,
        OP_DUP = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DIV,
        S_FIN
    } valu_state_e;

    // Sliced to the element width by users.
    localparam logic [63:0] DIV_DIVZERO_Q = '1;

endpackage

// File: rtl/valu_div_iter.sv
// Single-lane restoring divider, one quotient bit per cycle; divisor 0 yields all ones.
// Latency: start edge does iteration 1, valid high EW cycles after start.
// Backpressure: none; a new start restarts the divider at any time.
module valu_div_iter
    import valu_pkg::*;
#(
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [EW-1:0] dividend,
    input  logic [EW-1:0] divisor,
    output logic [EW-1:0] quotient,
    output logic          valid
);

    localparam int CW = $clog2(EW + 1);

    logic [EW-1:0] r_rem;
    logic [EW-1:0] r_quo;
    logic [EW-1:0] r_div;
    logic [CW-1:0] r_cnt;
    logic          r_loaded;

    logic [EW-1:0] w_rem_in;
    logic [EW-1:0] w_quo_in;
    logic [EW-1:0] w_div_in;
    logic [EW:0]   w_shift;
    logic          w_ge;
    logic [EW-1:0] w_rem_next;

    // On start the step runs on the fresh operands so iteration 1 costs no load cycle.
    assign w_rem_in   = start ? '0 : r_rem;
    assign w_quo_in   = start ? dividend : r_quo;
    assign w_div_in   = start ? divisor : r_div;
    assign w_shift    = {w_rem_in, w_quo_in[EW-1]};
    assign w_ge       = w_shift >= {1'b0, w_div_in};
    assign w_rem_next = w_ge ? (w_shift[EW-1:0] - w_div_in) : w_shift[EW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_loaded <= 1'b0;
        end else begin
            if (start || (r_cnt != '0)) begin
                r_rem <= w_rem_next;
                r_quo <= {w_quo_in[EW-2:0], w_ge};
                r_div <= w_div_in;
                r_cnt <= start ? CW'(EW - 1) : (r_cnt - 1'b1);
            end
            r_loaded <= r_loaded | start;
        end
    end

    assign valid    = r_loaded && (r_cnt == '0);
    assign quotient = (r_div == '0) ? DIV_DIVZERO_Q[EW-1:0] : r_quo;

endmodule

// File: rtl/vector_alu_exec.sv
// Lane-serial vector ALU (ADD/SUB/MOV/MUL/DIV/CMP/NOP/DUP); VALU_SAT_EN enables ADD/SUB/MUL clamping.
// Latency: start at T -> done at T+LANES+1, DIV T+LANES*(EW+1)+1, NOP T+1.
// Backpressure: start only accepted in IDLE; ignored while busy and during the done cycle.
module vector_alu_exec
    import valu_pkg::*;
#(
    parameter int LANES = 4,
    parameter int EW    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          alu_control,
    input  logic                src_a,
    input  logic [LANES*EW-1:0] vec_a,
    input  logic [LANES*EW-1:0] vec_b,
    output logic                busy,
    output logic                done,
    output logic [LANES*EW-1:0] result,
    output logic [LANES-1:0]    cmp_eq,
    output logic                flag_z,
    output logic                flag_n
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW = $clog2(EW + 1);

    valu_state_e         r_state;
    valu_state_e         w_next;
    alu_op_e             r_op;
    logic [LANES*EW-1:0] r_a;
    logic [LANES*EW-1:0] r_b;
    logic [LW-1:0]       r_lane;
    logic [PW-1:0]       r_phase;
    logic [LANES*EW-1:0] r_result;
    logic [LANES-1:0]    r_cmp_eq;
    logic                r_flag_z;
    logic                r_flag_n;

    logic                w_last_lane;
    logic                w_last_phase;
    logic [EW-1:0]       w_a_lane;
    logic [EW-1:0]       w_b_lane;
    logic [EW-1:0]       w_cur_lane;
    logic [EW-1:0]       w_diff;
    logic [EW-1:0]       w_add_res;
    logic [EW-1:0]       w_sub_res;
    logic [EW-1:0]       w_mul_res;
    logic [EW-1:0]       w_lane_res;
    logic                w_lane_eq;
    logic [LANES-1:0]    w_eq_mask;
    logic                w_div_start;
    logic [EW-1:0]       w_div_q;
    logic                w_div_vld;

    assign w_last_lane  = (r_lane == LW'(LANES - 1));
    assign w_last_phase = (r_phase == PW'(EW));
    assign w_a_lane     = r_a[r_lane*EW +: EW];
    assign w_b_lane     = r_b[r_lane*EW +: EW];
    assign w_cur_lane   = r_result[r_lane*EW +: EW];
    assign w_diff       = w_a_lane - w_b_lane;
    assign w_lane_eq    = (w_a_lane == w_b_lane);

`ifdef VALU_SAT_EN
    logic [EW:0]     w_sum;
    logic [2*EW-1:0] w_prod;

    assign w_sum     = {1'b0, w_a_lane} + {1'b0, w_b_lane};
    assign w_prod    = {{EW{1'b0}}, w_a_lane} * {{EW{1'b0}}, w_b_lane};
    assign w_add_res = w_sum[EW] ? '1 : w_sum[EW-1:0];
    assign w_sub_res = (w_a_lane < w_b_lane) ? '0 : w_diff;
    assign w_mul_res = (|w_prod[2*EW-1:EW]) ? '1 : w_prod[EW-1:0];
`else
    assign w_add_res = w_a_lane + w_b_lane;
    assign w_sub_res = w_diff;
    assign w_mul_res = w_a_lane * w_b_lane;
`endif

    // CMP and NOP fall through to the held lane value, so RUN can write unconditionally.
    always_comb begin
        w_lane_res = w_cur_lane;
        case (r_op)
            OP_ADD:  w_lane_res = w_add_res;
            OP_SUB:  w_lane_res = w_sub_res;
            OP_MOV:  w_lane_res = w_b_lane;
            OP_MUL:  w_lane_res = w_mul_res;
            OP_DUP:  w_lane_res = r_b[EW-1:0];
            default: w_lane_res = w_cur_lane;
        endcase
    end

    always_comb begin
        w_eq_mask         = r_cmp_eq;
        w_eq_mask[r_lane] = w_lane_eq;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (alu_op_e'(alu_control))
                        OP_DIV:  w_next = S_DIV;
                        OP_NOP:  w_next = S_FIN;
                        default: w_next = S_RUN;
                    endcase
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last_lane) w_next = S_FIN;
            end
            S_DIV: begin
                busy = 1'b1;
                if (w_last_lane && w_last_phase) w_next = S_FIN;
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_div_start = (r_state == S_DIV) && (r_phase == '0);

    valu_div_iter #(.EW(EW)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (w_div_start),
        .dividend (w_a_lane),
        .divisor  (w_b_lane),
        .quotient (w_div_q),
        .valid    (w_div_vld)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= OP_NOP;
            r_a      <= '0;
            r_b      <= '0;
            r_lane   <= '0;
            r_phase  <= '0;
            r_result <= '0;
            r_cmp_eq <= '0;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= alu_op_e'(alu_control);
                        r_a     <= src_a ? '0 : vec_a;
                        r_b     <= vec_b;
                        r_lane  <= '0;
                        r_phase <= '0;
                    end
                end
                S_RUN: begin
                    if (r_op == OP_CMP) begin
                        r_cmp_eq[r_lane] <= w_lane_eq;
                        if (r_lane == '0) r_flag_n <= w_diff[EW-1];
                        if (w_last_lane) r_flag_z <= &w_eq_mask;
                    end
                    r_result[r_lane*EW +: EW] <= w_lane_res;
                    if (!w_last_lane) r_lane <= r_lane + 1'b1;
                end
                S_DIV: begin
                    // Phases 0..EW-1 iterate the divider, phase EW writes the quotient back.
                    if (w_last_phase) begin
                        if (w_div_vld) r_result[r_lane*EW +: EW] <= w_div_q;
                        r_phase <= '0;
                        if (!w_last_lane) r_lane <= r_lane + 1'b1;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign cmp_eq = r_cmp_eq;
    assign flag_z = r_flag_z;
    assign flag_n = r_flag_n;

endmodule
